// File: rtl/cache_ri_refill_if.sv
// Signal bundle between the line refill engine and the controller, data RAM,
// dre RAM and Avalon-MM read master.
interface cache_ri_refill_if #(
    parameter int LINE_WIDTH   = 4,
    parameter int OFFSET_WIDTH = 3
);
    localparam int ADDR_WIDTH = LINE_WIDTH + OFFSET_WIDTH;

    logic                  start;
    logic [LINE_WIDTH-1:0] lineIndex;
    logic [1:0]            channel;
    logic [31:0]           memBase;
    logic                  busy;
    logic                  done;

    logic [ADDR_WIDTH-1:0] dre_readAddress;
    logic [1:0]            dre_readChannel;
    logic [3:0]            dre_readRe;
    logic [ADDR_WIDTH-1:0] dre_writeAddress;
    logic [1:0]            dre_writeChannel;
    logic                  dre_writeEnable;
    logic [3:0]            dre_writeRe;

    logic [ADDR_WIDTH-1:0] ram_writeAddress;
    logic [1:0]            ram_writeChannel;
    logic [31:0]           ram_writeData;
    logic [3:0]            ram_writeByteEnable;
    logic                  ram_writeEnable;

    logic [31:0]           av_address;
    logic                  av_read;
    logic                  av_waitrequest;
    logic                  av_readdatavalid;
    logic [31:0]           av_readdata;

    modport master (
        input  start, lineIndex, channel, memBase,
        output busy, done,
        output dre_readAddress, dre_readChannel,
        input  dre_readRe,
        output dre_writeAddress, dre_writeChannel, dre_writeEnable, dre_writeRe,
        output ram_writeAddress, ram_writeChannel, ram_writeData,
        output ram_writeByteEnable, ram_writeEnable,
        output av_address, av_read,
        input  av_waitrequest, av_readdatavalid, av_readdata
    );

    modport slave (
        output start, lineIndex, channel, memBase,
        input  busy, done,
        input  dre_readAddress, dre_readChannel,
        output dre_readRe,
        input  dre_writeAddress, dre_writeChannel, dre_writeEnable, dre_writeRe,
        input  ram_writeAddress, ram_writeChannel, ram_writeData,
        input  ram_writeByteEnable, ram_writeEnable,
        input  av_address, av_read,
        output av_waitrequest, av_readdatavalid, av_readdata
    );
endinterface

// File: rtl/cache_ri_refill.sv
// Refills one cache line word by word, fetching from memory only the words
// that still have unreadable bytes and merging around bytes already readable.
module cache_ri_refill #(
    parameter int LINE_WIDTH   = 4,
    parameter int OFFSET_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    cache_ri_refill_if.master  bus
);
    localparam int ADDR_WIDTH = LINE_WIDTH + OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = {OFFSET_WIDTH{1'b1}};
    localparam logic [OFFSET_WIDTH-1:0] WORD_ONE  = {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRE_ADDR = 3'd1,
        DRE_DATA = 3'd2,
        MEM_REQ  = 3'd3,
        MEM_WAIT = 3'd4,
        WRITE    = 3'd5,
        NEXT     = 3'd6
    } state_t;

    state_t                     state_r;
    state_t                     stateNext_s;
    logic                       captureData_s;
    logic                       lastWord_s;
    logic                       doneNext_s;
    logic [LINE_WIDTH-1:0]      lineIndex_r;
    logic [1:0]                 channel_r;
    logic [31:OFFSET_WIDTH+2]   memBase_r;
    logic [OFFSET_WIDTH-1:0]    wordCnt_r;
    logic [3:0]                 reReg_r;
    logic [31:0]                readData_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       avRead_r;
    logic                       ramWe_r;
    logic                       dreWe_r;
    logic [3:0]                 byteEn_r;
    logic                       unusedMemBaseLow_s;

    assign unusedMemBaseLow_s = ^bus.memBase[OFFSET_WIDTH+1:0];
    assign lastWord_s         = (wordCnt_r == LAST_WORD);
    assign doneNext_s         = (stateNext_s == NEXT) && lastWord_s;

    // Next-state decode; data is captured on the cycle readdatavalid is seen
    always_comb begin
        stateNext_s   = state_r;
        captureData_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) stateNext_s = DRE_ADDR;
                else           stateNext_s = IDLE;
            end
            DRE_ADDR: stateNext_s = DRE_DATA;
            DRE_DATA: begin
                if (bus.dre_readRe == 4'hF) stateNext_s = NEXT;
                else                        stateNext_s = MEM_REQ;
            end
            MEM_REQ: begin
                if (bus.av_waitrequest) begin
                    stateNext_s = MEM_REQ;
                end else if (bus.av_readdatavalid) begin
                    stateNext_s   = WRITE;
                    captureData_s = 1'b1;
                end else begin
                    stateNext_s = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.av_readdatavalid) begin
                    stateNext_s   = WRITE;
                    captureData_s = 1'b1;
                end else begin
                    stateNext_s = MEM_WAIT;
                end
            end
            WRITE: stateNext_s = NEXT;
            NEXT: begin
                if (lastWord_s) stateNext_s = IDLE;
                else            stateNext_s = DRE_ADDR;
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // State, latched request and registered strobes decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            lineIndex_r <= '0;
            channel_r   <= 2'b00;
            memBase_r   <= '0;
            wordCnt_r   <= '0;
            reReg_r     <= 4'h0;
            readData_r  <= 32'h0000_0000;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            avRead_r    <= 1'b0;
            ramWe_r     <= 1'b0;
            dreWe_r     <= 1'b0;
            byteEn_r    <= 4'h0;
        end else begin
            state_r <= stateNext_s;
            if (state_r == IDLE && bus.start) begin
                lineIndex_r <= bus.lineIndex;
                channel_r   <= bus.channel;
                memBase_r   <= bus.memBase[31:OFFSET_WIDTH+2];
                wordCnt_r   <= '0;
            end else if (state_r == NEXT && !lastWord_s) begin
                wordCnt_r <= wordCnt_r + WORD_ONE;
            end
            if (state_r == DRE_DATA) reReg_r <= bus.dre_readRe;
            if (captureData_s)       readData_r <= bus.av_readdata;
            // busy drops in the same cycle the done pulse is presented
            busy_r   <= (stateNext_s != IDLE) && !doneNext_s;
            done_r   <= doneNext_s;
            avRead_r <= (stateNext_s == MEM_REQ);
            ramWe_r  <= (stateNext_s == WRITE);
            dreWe_r  <= (stateNext_s == WRITE);
            byteEn_r <= (stateNext_s == WRITE) ? ~reReg_r : 4'h0;
        end
    end

    assign bus.busy                = busy_r;
    assign bus.done                = done_r;
    assign bus.dre_readAddress     = {lineIndex_r, wordCnt_r};
    assign bus.dre_readChannel     = channel_r;
    assign bus.dre_writeAddress    = {lineIndex_r, wordCnt_r};
    assign bus.dre_writeChannel    = channel_r;
    assign bus.dre_writeEnable     = dreWe_r;
    assign bus.dre_writeRe         = 4'hF;
    assign bus.ram_writeAddress    = {lineIndex_r, wordCnt_r};
    assign bus.ram_writeChannel    = channel_r;
    assign bus.ram_writeData       = readData_r;
    assign bus.ram_writeByteEnable = byteEn_r;
    assign bus.ram_writeEnable     = ramWe_r;
    assign bus.av_address          = {memBase_r, wordCnt_r, 2'b00};
    assign bus.av_read             = avRead_r;
endmodule

// File: tb/tb_cache_ri_refill.sv
// Directed bench for cache_ri_refill: dre RAM and Avalon slave models,
// a table of refill scenarios plus a hand-written mid-line reset sequence.
module tb_cache_ri_refill;
    localparam int LW = 4;
    localparam int OW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ri_refill_if #(.LINE_WIDTH(LW), .OFFSET_WIDTH(OW)) bus ();
    cache_ri_refill #(.LINE_WIDTH(LW), .OFFSET_WIDTH(OW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0]  line;
        logic [1:0]  chan;
        logic [31:0] base;
        logic [31:0] expBase;
        logic [31:0] dreInit;
        logic [31:0] expBe;     // per-word byte enable, 0 = word skipped
        int          stall;
        int          lat;
        int          expReads;
        int          expCycles; // start cycle to done cycle
        int          pokeAt;    // cycle to pulse a stray start, 0 = none
    } vec_t;

    typedef struct {
        logic [6:0]  addr;
        logic [1:0]  chan;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // dre RAM: synchronous read, DUT write port with a bench preload port
    bit   [3:0] dreMem [512];
    logic       tbWe = 1'b0;
    logic [8:0] tbIdx = 9'd0;
    logic [3:0] tbData = 4'h0;
    always @(posedge clk) begin
        bus.dre_readRe <= dreMem[{bus.dre_readChannel, bus.dre_readAddress}];
        if (bus.dre_writeEnable) dreMem[{bus.dre_writeChannel, bus.dre_writeAddress}] <= bus.dre_writeRe;
        else if (tbWe)           dreMem[tbIdx] <= tbData;
    end

    // Avalon slave: programmable stall count and read latency
    int          cfgStall = 0;
    int          cfgLat   = 1;
    int          stallCnt = 0;
    int          pendCnt  = 0;
    logic [31:0] pendAddr = 32'h0;
    logic [31:0] reads[$];
    assign bus.av_waitrequest = bus.av_read && (stallCnt < cfgStall);
    always @(posedge clk) begin
        bus.av_readdatavalid <= 1'b0;
        if (pendCnt > 1) begin
            pendCnt <= pendCnt - 1;
        end else if (pendCnt == 1) begin
            bus.av_readdatavalid <= 1'b1;
            bus.av_readdata      <= memData(pendAddr);
            pendCnt              <= 0;
        end
        if (bus.av_read && bus.av_waitrequest) begin
            stallCnt <= stallCnt + 1;
        end else if (bus.av_read) begin
            stallCnt <= 0;
            reads.push_back(bus.av_address);
            pendAddr <= bus.av_address;
            if (cfgLat <= 1) begin
                bus.av_readdatavalid <= 1'b1;
                bus.av_readdata      <= memData(bus.av_address);
            end else begin
                pendCnt <= cfgLat - 1;
            end
        end
    end

    // Monitor: write strobe pairing, stall stability, done counting
    wr_t         writes[$];
    int          doneCnt = 0;
    logic        prevRdv = 1'b0;
    logic        prevStall = 1'b0;
    logic [31:0] prevAvAddr = 32'h0;
    always @(negedge clk) begin
        if (bus.ram_writeEnable || bus.dre_writeEnable) begin
            check("we_pair", bus.dre_writeEnable, bus.ram_writeEnable);
            check("dre_wr_addr", bus.dre_writeAddress, bus.ram_writeAddress);
            check("dre_wr_chan", bus.dre_writeChannel, bus.ram_writeChannel);
            check("dre_wr_re", bus.dre_writeRe, 32'h0000_000F);
            check("wr_after_rdv", prevRdv, 32'h1);
            writes.push_back('{addr: bus.ram_writeAddress, chan: bus.ram_writeChannel,
                               be: bus.ram_writeByteEnable, data: bus.ram_writeData});
        end
        if (prevStall) begin
            check("stall_read_held", bus.av_read, 32'h1);
            check("stall_addr_held", bus.av_address, prevAvAddr);
        end
        if (bus.done) doneCnt <= doneCnt + 1;
        prevRdv    <= bus.av_readdatavalid;
        prevStall  <= bus.av_read && bus.av_waitrequest;
        prevAvAddr <= bus.av_address;
    end

    function automatic logic [31:0] dreLine(input logic [3:0] line, input logic [1:0] chan);
        logic [31:0] r;
        r = 32'h0;
        for (int w = 0; w < 8; w++) r[4*w +: 4] = dreMem[{chan, line, w[2:0]}];
        return r;
    endfunction

    task automatic preloadLine(input logic [3:0] line, input logic [1:0] chan, input logic [31:0] init);
        for (int w = 0; w < 8; w++) begin
            tbIdx  = {chan, line, w[2:0]};
            tbData = init[4*w +: 4];
            tbWe   = 1'b1;
            @(negedge clk);
        end
        tbWe = 1'b0;
    endtask

    task automatic runRefill(input vec_t v, input bit preload);
        int rd0, wr0, dn0, n, k;
        bit gotDone;
        cfgStall = v.stall;
        cfgLat   = v.lat;
        if (preload) preloadLine(v.line, v.chan, v.dreInit);
        rd0 = reads.size();
        wr0 = writes.size();
        dn0 = doneCnt;
        bus.start = 1'b1; bus.lineIndex = v.line; bus.channel = v.chan; bus.memBase = v.base;
        n = 0;
        gotDone = 1'b0;
        while (!gotDone && n < 3000) begin
            @(negedge clk);
            n++;
            if (n == v.pokeAt) begin
                bus.start = 1'b1; bus.lineIndex = 4'd9; bus.channel = 2'd0; bus.memBase = 32'hFFFF_0000;
            end else begin
                bus.start = 1'b0;
            end
            if (n == 1) begin
                check("busy_after_start", bus.busy, 32'h1);
                check("first_dre_addr", bus.dre_readAddress, {v.line, 3'd0});
            end
            if (bus.done) gotDone = 1'b1;
        end
        check("done_seen", gotDone, 32'h1);
        check("refill_cycles", n, v.expCycles);
        check("busy_low_at_done", bus.busy, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        check("done_single", bus.done, 32'h0);
        @(negedge clk);
        check("start_ignored_busy", bus.busy, 32'h0);
        check("done_pulses", doneCnt - dn0, 32'h1);
        check("read_count", reads.size() - rd0, v.expReads);
        check("write_count", writes.size() - wr0, v.expReads);
        k = 0;
        for (int w = 0; w < 8; w++) begin
            if (v.expBe[4*w +: 4] != 4'h0) begin
                if (rd0 + k < reads.size())
                    check("read_addr", reads[rd0 + k], v.expBase + 32'(4 * w));
                if (wr0 + k < writes.size()) begin
                    check("wr_addr", writes[wr0 + k].addr, {v.line, w[2:0]});
                    check("wr_chan", writes[wr0 + k].chan, v.chan);
                    check("wr_be", writes[wr0 + k].be, v.expBe[4*w +: 4]);
                    check("wr_data", writes[wr0 + k].data, memData(v.expBase + 32'(4 * w)));
                end
                k++;
            end
        end
        check("dre_line_full", dreLine(v.line, v.chan), 32'hFFFF_FFFF);
    endtask

    vec_t tbl[4];
    vec_t recov;

    initial begin
        int rd0, wr0, n;
        bus.start = 1'b0; bus.lineIndex = 4'd0; bus.channel = 2'd0; bus.memBase = 32'h0;
        tbl[0] = '{line: 4'd5, chan: 2'd2, base: 32'h0000_1240, expBase: 32'h0000_1240,
                   dreInit: 32'h0000_0000, expBe: 32'hFFFF_FFFF, stall: 0, lat: 1,
                   expReads: 8, expCycles: 48, pokeAt: 14};
        tbl[1] = '{line: 4'd3, chan: 2'd1, base: 32'h0000_2000, expBase: 32'h0000_2000,
                   dreInit: 32'h0000_5000, expBe: 32'hFFFF_AFFF, stall: 0, lat: 1,
                   expReads: 8, expCycles: 48, pokeAt: 48};
        tbl[2] = '{line: 4'd6, chan: 2'd0, base: 32'h0000_3300, expBase: 32'h0000_3300,
                   dreInit: 32'hF000_000F, expBe: 32'h0FFF_FFF0, stall: 0, lat: 1,
                   expReads: 6, expCycles: 42, pokeAt: 0};
        tbl[3] = '{line: 4'd7, chan: 2'd3, base: 32'hABCD_007C, expBase: 32'hABCD_0060,
                   dreInit: 32'h00F0_0300, expBe: 32'hFF0F_FCFF, stall: 4, lat: 3,
                   expReads: 7, expCycles: 87, pokeAt: 0};
        recov  = '{line: 4'd5, chan: 2'd2, base: 32'h0000_1240, expBase: 32'h0000_1240,
                   dreInit: 32'h0000_0000, expBe: 32'hFFFF_0000, stall: 0, lat: 1,
                   expReads: 4, expCycles: 36, pokeAt: 0};

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 32'h0);
        check("rst_done", bus.done, 32'h0);
        check("rst_av_read", bus.av_read, 32'h0);
        check("rst_ram_we", bus.ram_writeEnable, 32'h0);
        check("rst_dre_we", bus.dre_writeEnable, 32'h0);
        check("rst_av_addr", bus.av_address, 32'h0);
        check("rst_ram_addr", bus.ram_writeAddress, 32'h0);
        check("rst_ram_data", bus.ram_writeData, 32'h0);
        check("rst_ram_be", bus.ram_writeByteEnable, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) runRefill(tbl[i], 1'b1);

        // Reset while word 4 waits for its read data
        preloadLine(4'd5, 2'd2, 32'h0000_0000);
        cfgStall = 0;
        cfgLat   = 5;
        rd0 = reads.size();
        wr0 = writes.size();
        bus.start = 1'b1; bus.lineIndex = 4'd5; bus.channel = 2'd2; bus.memBase = 32'h0000_1240;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (reads.size() - rd0 < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_word4", reads.size() - rd0, 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", bus.busy, 32'h0);
        check("mid_rst_av_read", bus.av_read, 32'h0);
        check("mid_rst_ram_we", bus.ram_writeEnable, 32'h0);
        check("mid_rst_dre_we", bus.dre_writeEnable, 32'h0);
        check("mid_rst_writes", writes.size() - wr0, 32'd4);
        repeat (8) @(negedge clk);
        check("late_rdv_ignored", writes.size() - wr0, 32'd4);
        check("idle_after_rst", bus.busy, 32'h0);
        check("partial_dre_line", dreLine(4'd5, 2'd2), 32'h0000_FFFF);
        runRefill(recov, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
